// File: rtl/k_fifo_2deep_ctrl.sv
// k_fifo_2deep_ctrl
//   Pointer/flag controller for a small FIFO built around an external
//   dual-port RAM with a combinational read port. The controller owns the
//   write and read pointers. It drives the RAM write enable and the two
//   addresses, and it reports occupancy.
//
// Ports
//   clk, rst_n      : clock (posedge) and asynchronous active-low reset
//   flush           : synchronous clear of the FIFO contents; wins over push/pop
//   in_valid        : producer has a word on the RAM d bus
//   in_ready        : word is accepted this cycle (= !full)
//   out_valid       : RAM q holds the oldest word (= !empty)
//   out_ready       : consumer takes q this cycle
//   wen/waddr       : RAM write enable / write address
//   raddr           : RAM read address (q is combinational from raddr)
//   full/empty      : status flags
//   count           : stored words, 0..2**addr_w
//   ovf_err         : sticky, set by a push attempt while full; only reset clears it
module k_fifo_2deep_ctrl #(
    parameter int addr_w = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wen,
    output logic [addr_w-1:0] waddr,
    output logic [addr_w-1:0] raddr,
    output logic              full,
    output logic              empty,
    output logic [addr_w:0]   count,
    output logic              ovf_err
);

    localparam int PW = addr_w + 1;

    // The extra MSB on each pointer is a wrap bit. It separates full from
    // empty when the address bits match.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_err_q, ovf_err_d;
    logic          push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[addr_w] != rd_ptr_q[addr_w]) &&
                   (wr_ptr_q[addr_w-1:0] == rd_ptr_q[addr_w-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // in_ready depends only on registered state. A pop in the same cycle
    // never frees a slot for a push while full.
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign wen   = push && !flush;
    assign waddr = wr_ptr_q[addr_w-1:0];
    assign raddr = rd_ptr_q[addr_w-1:0];
    assign ovf_err = ovf_err_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_err_d = ovf_err_q || (in_valid && full);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_err_q <= ovf_err_d;
        end
    end

endmodule

// File: tb/tb_k_fifo_2deep_ctrl.sv
module tb_k_fifo_2deep_ctrl;

    localparam int AW    = 1;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, wen, full, empty, ovf_err;
    logic [AW-1:0] waddr, raddr;
    logic [AW:0]   count;
    logic [7:0]    din = 8'h00;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    k_fifo_2deep_ctrl #(.addr_w(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .wen(wen), .waddr(waddr), .raddr(raddr),
        .full(full), .empty(empty), .count(count), .ovf_err(ovf_err)
    );

    // External RAM: synchronous write, combinational read.
    always @(posedge clk) if (wen) mem[waddr] <= din;
    assign q = mem[raddr];

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Check every output against an expected occupancy picture.
    task automatic chk_all(input string tag, input int cnt, input int wen_e,
                           input int wa, input int ra, input int ovf, input int qe);
        cmp({tag, " count"},     int'(count),     cnt);
        cmp({tag, " empty"},     int'(empty),     int'(cnt == 0));
        cmp({tag, " full"},      int'(full),      int'(cnt == DEPTH));
        cmp({tag, " in_ready"},  int'(in_ready),  int'(cnt != DEPTH));
        cmp({tag, " out_valid"}, int'(out_valid), int'(cnt != 0));
        cmp({tag, " wen"},       int'(wen),       wen_e);
        cmp({tag, " waddr"},     int'(waddr),     wa);
        cmp({tag, " raddr"},     int'(raddr),     ra);
        cmp({tag, " ovf_err"},   int'(ovf_err),   ovf);
        if (cnt != 0) cmp({tag, " q"}, int'(q), qe);
    endtask

    typedef struct {
        logic       fl, iv, ordy;
        logic [7:0] d;
        int         cnt, wen, wa, ra, ovf;
        logic [7:0] q;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                                input logic [7:0] d, input int cnt, input int w,
                                input int wa, input int ra, input int ovf,
                                input logic [7:0] qq);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
        v.cnt = cnt; v.wen = w; v.wa = wa; v.ra = ra; v.ovf = ovf; v.q = qq;
        return v;
    endfunction

    vec_t tbl [18];

    // Reference model state for the randomized phase.
    logic [7:0] mq [$];
    int         wcnt, rcnt, movf;

    initial begin
        // Each row gives the inputs applied in a cycle and the outputs
        // expected in that cycle, before its clock edge.
        //            fl  iv  or  d      cnt wen wa ra ovf q
        tbl[0]  = mk(0,  0,  0,  8'h00, 0,  0,  0, 0, 0, 8'h00); // idle after reset
        tbl[1]  = mk(0,  1,  0,  8'hA5, 0,  1,  0, 0, 0, 8'h00); // fill: A5 @0
        tbl[2]  = mk(0,  1,  0,  8'h3C, 1,  1,  1, 0, 0, 8'hA5); // fill: 3C @1
        tbl[3]  = mk(0,  1,  0,  8'h77, 2,  0,  0, 0, 0, 8'hA5); // overflow attempt
        tbl[4]  = mk(0,  0,  1,  8'h00, 2,  0,  0, 0, 1, 8'hA5); // drain A5, ovf sticky
        tbl[5]  = mk(0,  0,  1,  8'h00, 1,  0,  0, 1, 1, 8'h3C); // drain 3C
        tbl[6]  = mk(0,  0,  0,  8'h00, 0,  0,  0, 0, 1, 8'h00); // empty, raddr back at 0
        tbl[7]  = mk(0,  1,  1,  8'h11, 0,  1,  0, 0, 1, 8'h00); // push to empty, no fall-through
        tbl[8]  = mk(0,  1,  1,  8'h22, 1,  1,  1, 0, 1, 8'h11); // push+pop, count holds
        tbl[9]  = mk(0,  1,  1,  8'h33, 1,  1,  0, 1, 1, 8'h22);
        tbl[10] = mk(0,  1,  1,  8'h44, 1,  1,  1, 0, 1, 8'h33);
        tbl[11] = mk(0,  1,  1,  8'h55, 1,  1,  0, 1, 1, 8'h44);
        tbl[12] = mk(1,  1,  1,  8'h66, 1,  0,  1, 0, 1, 8'h55); // flush wins, wen low
        tbl[13] = mk(0,  0,  0,  8'h00, 0,  0,  0, 0, 1, 8'h00); // flushed
        tbl[14] = mk(0,  1,  0,  8'hAA, 0,  1,  0, 0, 1, 8'h00);
        tbl[15] = mk(0,  1,  0,  8'hBB, 1,  1,  1, 0, 1, 8'hAA);
        tbl[16] = mk(1,  1,  0,  8'hCC, 2,  0,  0, 0, 1, 8'hAA); // flush while full
        tbl[17] = mk(0,  0,  0,  8'h00, 0,  0,  0, 0, 1, 8'h00); // ovf survives flush

        // Reset state, checked while rst_n is still low.
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            flush = tbl[i].fl; in_valid = tbl[i].iv; out_ready = tbl[i].ordy; din = tbl[i].d;
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].wen, tbl[i].wa,
                    tbl[i].ra, tbl[i].ovf, int'(tbl[i].q));
        end

        // Asynchronous reset between edges while holding two words.
        @(negedge clk); flush = 0; in_valid = 1; out_ready = 0; din = 8'hC1;
        @(negedge clk); din = 8'hC2;
        @(negedge clk); in_valid = 0;
        #1 cmp("pre-areset count", int'(count), 2);
        #1 rst_n = 1'b0;
        #1 chk_all("areset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("areset held", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk); in_valid = 1; din = 8'hD1;
        #1 chk_all("post-reset push", 0, 1, 0, 0, 0, 0);
        @(negedge clk); in_valid = 0;
        #1 chk_all("post-reset q", 1, 0, 1, 0, 0, 8'hD1);

        // Randomized traffic against a queue-based model.
        mq = '{8'hD1}; wcnt = 1; rcnt = 0; movf = 0;
        for (int c = 0; c < 400; c++) begin
            logic fl, iv, ordy;
            logic [7:0] d;
            int sz;
            @(negedge clk);
            fl = ($urandom_range(0, 15) == 0);
            iv = $urandom_range(0, 1) == 1;
            ordy = $urandom_range(0, 1) == 1;
            d = 8'($urandom);
            flush = fl; in_valid = iv; out_ready = ordy; din = d;
            sz = mq.size();
            #1;
            chk_all("rand", sz, int'(iv && sz < DEPTH && !fl), wcnt % DEPTH,
                    rcnt % DEPTH, movf, (sz != 0) ? int'(mq[0]) : 0);
            if (iv && sz == DEPTH) movf = 1;
            if (fl) begin
                mq.delete(); wcnt = 0; rcnt = 0;
            end else begin
                if (ordy && sz != 0) begin void'(mq.pop_front()); rcnt++; end
                if (iv && sz < DEPTH) begin mq.push_back(d); wcnt++; end
            end
        end

        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
